// File: rtl/burst_seq_gen.sv
// ----------------------------------------------------------------------------
// Module   : burst_seq_gen
// Brief    : Burst source; emits incrementing data beats at a fixed address,
//            throttled by enable, and pulses done after the last beat.
//            Optional macro BURST_SVA_EN compiles in stream-property assertions.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module burst_seq_gen #(
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int LENW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_seed,
  input  logic [LENW-1:0] req_len,
  input  logic            enable,
  output logic            valid,
  output logic [DW-1:0]   data,
  output logic [AW-1:0]   addr,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    BURST = 3'b010,
    DONE  = 3'b100
  } state_t;

  localparam logic [DW-1:0]   c_data_one = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [LENW-1:0] c_len_one  = {{(LENW-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [LENW-1:0] remaining_q, remaining_d;
  logic            first_q, first_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    addr_d      = addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    remaining_d = remaining_q;
    first_d     = first_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (req) begin
          addr_d      = req_addr;
          data_d      = req_seed;
          remaining_d = req_len;
          first_d     = 1'b1;
          busy_d      = 1'b1;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (enable) begin
          valid_d = 1'b1;
          first_d = 1'b0;
          // The seed was loaded at accept, so only later beats increment.
          if (!first_q) begin
            data_d = data_q + c_data_one;
          end
          if (remaining_q == '0) begin
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            remaining_d = remaining_q - c_len_one;
          end
        end
      end
      DONE: begin
        // Two cycles here: the first raises done, the second drops it.
        if (!done_q) begin
          done_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign addr  = addr_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef BURST_SVA_EN
  logic [DW-1:0] sva_last_data_q;
  logic          sva_seen_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sva_last_data_q <= '0;
      sva_seen_q      <= 1'b0;
    end else if (state_q == IDLE) begin
      sva_seen_q <= 1'b0;
    end else if (valid_q) begin
      sva_last_data_q <= data_q;
      sva_seen_q      <= 1'b1;
    end
  end

  a_busy_from_req: assert property (@(posedge clk) disable iff (reset)
    $rose(busy_q) |-> $past(req && (state_q == IDLE)));
  a_addr_stable: assert property (@(posedge clk) disable iff (reset)
    (busy_q && $past(busy_q)) |-> $stable(addr_q));
  a_data_incr: assert property (@(posedge clk) disable iff (reset)
    (valid_q && sva_seen_q) |-> (data_q == sva_last_data_q + c_data_one));
  a_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot(state_q));
  a_no_x: assert property (@(posedge clk) disable iff (reset)
    !$isunknown({valid_q, busy_q, done_q, data_q, addr_q}));
  a_done_after_busy: assert property (@(posedge clk) disable iff (reset)
    $fell(busy_q) |-> ##1 done_q);
  a_done_not_valid: assert property (@(posedge clk) disable iff (reset)
    done_q |-> !valid_q);
`endif

endmodule

`default_nettype wire

// File: tb/tb_burst_seq_gen.sv
// ----------------------------------------------------------------------------
// Module   : tb_burst_seq_gen
// Brief    : Directed vector bench for burst_seq_gen.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_burst_seq_gen;

  logic       clk;
  logic       reset;
  logic       req;
  logic [7:0] req_addr;
  logic [7:0] req_seed;
  logic [3:0] req_len;
  logic       enable;
  logic       valid;
  logic [7:0] data;
  logic [7:0] addr;
  logic       busy;
  logic       done;

  int n_checks;
  int n_pass;

  burst_seq_gen #(.DW(8), .AW(8), .LENW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_seed (req_seed),
    .req_len  (req_len),
    .enable   (enable),
    .valid    (valid),
    .data     (data),
    .addr     (addr),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of outputs: {valid, data, addr, busy, done}
  typedef struct {
    logic        req;
    logic [7:0]  addr;
    logic [7:0]  seed;
    logic [3:0]  len;
    logic        en;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [18:0] pk(input logic v, input logic [7:0] d,
                                      input logic [7:0] a, input logic b,
                                      input logic dn);
    return {v, d, a, b, dn};
  endfunction

  task automatic add(input logic r, input logic [7:0] a, input logic [7:0] s,
                     input logic [3:0] l, input logic e, input logic v,
                     input logic [7:0] ed, input logic [7:0] ea,
                     input logic eb, input logic edn);
    vec_t t;
    t.req = r; t.addr = a; t.seed = s; t.len = l; t.en = e;
    t.exp = pk(v, ed, ea, eb, edn);
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [18:0] exp);
    logic [18:0] act;
    act = {valid, data, addr, busy, done};
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got v=%b d=%h a=%h b=%b dn=%b, want v=%b d=%h a=%h b=%b dn=%b",
               name, act[18], act[17:10], act[9:2], act[1], act[0],
               exp[18], exp[17:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [7:0] a, input logic [7:0] s,
                       input logic [3:0] l, input logic e);
    req = r; req_addr = a; req_seed = s; req_len = l; enable = e;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);

    // Test 1: addr 0x40, seed 0x10, len 3, enable high
    add(1, 8'h40, 8'h10, 4'd3, 1, 0, 8'h10, 8'h40, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 1, 8'h10, 8'h40, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 1, 8'h11, 8'h40, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 1, 8'h12, 8'h40, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 1, 8'h13, 8'h40, 0, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 0, 8'h13, 8'h40, 0, 1);
    add(0, 8'h00, 8'h00, 4'd0, 1, 0, 8'h13, 8'h40, 0, 0);
    // Test 2: data wraps 0xFF -> 0x00
    add(1, 8'h22, 8'hFE, 4'd2, 1, 0, 8'hFE, 8'h22, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 1, 8'hFE, 8'h22, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 1, 8'hFF, 8'h22, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 1, 8'h00, 8'h22, 0, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 0, 8'h00, 8'h22, 0, 1);
    add(0, 8'h00, 8'h00, 4'd0, 1, 0, 8'h00, 8'h22, 0, 0);
    // Test 3: len 4, enable 1,0,0,1,1,0,1 then 1 for the fifth beat
    add(1, 8'h55, 8'h30, 4'd4, 1, 0, 8'h30, 8'h55, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 1, 8'h30, 8'h55, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 0, 0, 8'h30, 8'h55, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 0, 0, 8'h30, 8'h55, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 1, 8'h31, 8'h55, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 1, 8'h32, 8'h55, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 0, 0, 8'h32, 8'h55, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 1, 8'h33, 8'h55, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 1, 8'h34, 8'h55, 0, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 0, 8'h34, 8'h55, 0, 1);
    add(0, 8'h00, 8'h00, 4'd0, 1, 0, 8'h34, 8'h55, 0, 0);
    // Test 4: req mid-burst and in DONE is ignored
    add(1, 8'h60, 8'h00, 4'd2, 1, 0, 8'h00, 8'h60, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 1, 8'h00, 8'h60, 1, 0);
    add(1, 8'h99, 8'h77, 4'd7, 1, 1, 8'h01, 8'h60, 1, 0);
    add(0, 8'h00, 8'h00, 4'd0, 1, 1, 8'h02, 8'h60, 0, 0);
    add(1, 8'h99, 8'h77, 4'd7, 1, 0, 8'h02, 8'h60, 0, 1);
    add(0, 8'h00, 8'h00, 4'd0, 1, 0, 8'h02, 8'h60, 0, 0);

    step();
    step();
    check("reset_state", pk(0, 8'h00, 8'h00, 0, 0));
    reset = 1'b0;
    step();
    check("idle_after_reset", pk(0, 8'h00, 8'h00, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].addr, vecs[i].seed, vecs[i].len, vecs[i].en);
      step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Test 5: asynchronous reset during the third beat of a len 7 burst
    drive(1'b1, 8'h70, 8'h05, 4'd7, 1'b1);
    step();
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b1);
    step();
    step();
    step();
    check("third_beat", pk(1, 8'h07, 8'h70, 1, 0));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_mid", pk(0, 8'h00, 8'h00, 0, 0));
    step();
    reset = 1'b0;
    step();
    check("post_reset_idle", pk(0, 8'h00, 8'h00, 0, 0));
    drive(1'b1, 8'h12, 8'hAA, 4'd0, 1'b1);
    step();
    check("len0_accept", pk(0, 8'hAA, 8'h12, 1, 0));
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b1);
    step();
    check("len0_beat", pk(1, 8'hAA, 8'h12, 0, 0));
    step();
    check("len0_done", pk(0, 8'hAA, 8'h12, 0, 1));
    step();
    check("len0_idle", pk(0, 8'hAA, 8'h12, 0, 0));

    // Test 6: reset and req together keep the block idle
    reset = 1'b1;
    drive(1'b1, 8'h33, 8'h44, 4'd3, 1'b1);
    step();
    check("reset_with_req", pk(0, 8'h00, 8'h00, 0, 0));
    reset = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b1);
    step();
    check("idle_after_reset_req", pk(0, 8'h00, 8'h00, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
